// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, per-stage
// stall encodings, default vectors and a PC alignment helper.
package pipe_ctrl_pkg;

   localparam int unsigned PC_W      = 32;
   localparam int unsigned STALL_W   = 6;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned FLUSH_C_W = 3;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Stall bit order {wb,mem,ex,id,if,pc}, bit0 = pc
   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

   localparam logic [PC_W-1:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [PC_W-1:0] EXC_VEC_DEF   = 32'h0000_0020;

   // Instruction fetch is word aligned; low address bits are always dropped
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Consecutive-stall counter with sticky watchdog flag.
// Ports: clk, rst (sync, active-high), i_run (controller in RUN),
//        i_stalled (stall vector non-zero), o_stall_cnt, o_wdog_err.
module stall_wdog
   import pipe_ctrl_pkg::*;
#(
   parameter logic [CNT_W-1:0] WDOG_LIMIT = 8'd64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic             i_stalled,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic             o_wdog_err
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_wdog;
   logic             w_inc;
   logic [CNT_W-1:0] w_cnt_next;

   // Saturating increment, only counted while running
   always_comb begin
      w_inc      = i_run & i_stalled;
      w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_wdog <= 1'b0;
      end else begin
         if (!i_stalled)
            r_cnt <= '0;
         else if (w_inc)
            r_cnt <= w_cnt_next;
         if (w_inc && (w_cnt_next == WDOG_LIMIT))
            r_wdog <= 1'b1;
      end
   end

   // Reset forces zero on the outputs immediately, not only after the edge
   assign o_stall_cnt = rst ? '0 : r_cnt;
   assign o_wdog_err  = rst ? 1'b0 : r_wdog;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: per-stage stalls, exception flush
// sequencing, branch redirect with deferral across stalls, and a stall
// watchdog.
// Ports: clk, rst (sync, active-high); stallreq_id, stallreq_ex;
//        exc_valid, exc_eret, epc; branch_valid, branch_target;
//        stall[5:0], flush, pc_load, pc_new[31:0], stall_cnt[7:0], wdog_err.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [PC_W-1:0]  RESET_VEC    = RESET_VEC_DEF,
   parameter logic [PC_W-1:0]  EXC_VEC      = EXC_VEC_DEF,
   parameter int unsigned      FLUSH_CYCLES = 2,
   parameter logic [CNT_W-1:0] WDOG_LIMIT   = 8'd64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               exc_valid,
   input  logic               exc_eret,
   input  logic [PC_W-1:0]    epc,
   input  logic               branch_valid,
   input  logic [PC_W-1:0]    branch_target,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic               pc_load,
   output logic [PC_W-1:0]    pc_new,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic               wdog_err
);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [FLUSH_C_W-1:0]   r_flush_cnt;
   logic                   r_pend_valid;
   logic [PC_W-1:0]        r_pend_tgt;

   logic [STALL_W-1:0]     w_stall_req;
   logic                   w_run;
   logic                   w_exc;
   logic                   w_req_stall;
   logic                   w_issue_pend;
   logic                   w_capture;
   logic                   w_stalled;

   // Decoded request conditions shared by next-state, outputs and datapath
   always_comb begin
      w_stall_req  = stallreq_ex ? STALL_EX : (stallreq_id ? STALL_ID : STALL_NONE);
      w_run        = (r_state == ST_RUN);
      w_exc        = w_run & exc_valid;
      w_req_stall  = (w_stall_req != STALL_NONE);
      w_issue_pend = w_run & ~exc_valid & ~w_req_stall & r_pend_valid;
      // A branch is deferred when stalled or when a pending one takes this slot
      w_capture    = w_run & ~exc_valid & branch_valid & (w_req_stall | r_pend_valid);
      w_stalled    = (stall != STALL_NONE);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_HOLD;
      else
         r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_HOLD:  w_state_next = ST_RUN;
         ST_RUN:   if (exc_valid) w_state_next = ST_FLUSH;
         ST_FLUSH: if (r_flush_cnt <= FLUSH_C_W'(1)) w_state_next = ST_RUN;
         default:  w_state_next = ST_HOLD;
      endcase
   end

   // Output logic; rst overrides to the HOLD values combinationally
   always_comb begin
      stall   = STALL_NONE;
      flush   = 1'b0;
      pc_load = 1'b0;
      pc_new  = '0;
      if (rst || (r_state == ST_HOLD)) begin
         stall   = STALL_ALL;
         pc_load = 1'b1;
         pc_new  = align_pc(RESET_VEC);
      end else if (r_state == ST_FLUSH) begin
         flush = 1'b1;
      end else if (r_state == ST_RUN) begin
         if (exc_valid) begin
            flush   = 1'b1;
            pc_load = 1'b1;
            pc_new  = align_pc(exc_eret ? epc : EXC_VEC);
         end else if (w_req_stall) begin
            stall = w_stall_req;
         end else if (r_pend_valid) begin
            pc_load = 1'b1;
            pc_new  = align_pc(r_pend_tgt);
         end else if (branch_valid) begin
            pc_load = 1'b1;
            pc_new  = align_pc(branch_target);
         end
      end
   end

   // Flush down-counter and deferred branch register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush_cnt  <= '0;
         r_pend_valid <= 1'b0;
         r_pend_tgt   <= '0;
      end else begin
         if (w_exc)
            r_flush_cnt <= FLUSH_C_W'(FLUSH_CYCLES);
         else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0))
            r_flush_cnt <= r_flush_cnt - FLUSH_C_W'(1);

         if (w_exc) begin
            r_pend_valid <= 1'b0;
         end else if (w_capture) begin
            r_pend_valid <= 1'b1;
            r_pend_tgt   <= branch_target;
         end else if (w_issue_pend) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   stall_wdog #(
      .WDOG_LIMIT (WDOG_LIMIT)
   ) u_stall_wdog (
      .clk         (clk),
      .rst         (rst),
      .i_run       (w_run),
      .i_stalled   (w_stalled),
      .o_stall_cnt (stall_cnt),
      .o_wdog_err  (wdog_err)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

   localparam logic [31:0] RESET_VEC    = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC      = 32'h0000_0020;
   localparam int          FLUSH_CYCLES = 2;
   localparam int          WDOG_LIMIT   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id, stallreq_ex, exc_valid, exc_eret, branch_valid;
   logic [31:0] epc, branch_target;
   logic [5:0]  stall;
   logic        flush, pc_load, wdog_err;
   logic [31:0] pc_new;
   logic [7:0]  stall_cnt;

   pipe_ctrl #(
      .RESET_VEC    (RESET_VEC),
      .EXC_VEC      (EXC_VEC),
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .WDOG_LIMIT   (8'(WDOG_LIMIT))
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_id   (stallreq_id),
      .stallreq_ex   (stallreq_ex),
      .exc_valid     (exc_valid),
      .exc_eret      (exc_eret),
      .epc           (epc),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .stall         (stall),
      .flush         (flush),
      .pc_load       (pc_load),
      .pc_new        (pc_new),
      .stall_cnt     (stall_cnt),
      .wdog_err      (wdog_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 = post-reset hold, 1 = running, 2 = flushing
   int          m_phase      = 0;
   int          m_flush_left = 0;
   bit          m_pend       = 1'b0;
   logic [31:0] m_pend_tgt   = '0;
   int          m_cnt        = 0;
   bit          m_wdog       = 1'b0;

   logic [5:0]  e_stall;
   logic        e_flush, e_load, e_wdog;
   logic [31:0] e_pc;
   int          e_cnt;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   function automatic void model_eval();
      e_stall = 6'h00; e_flush = 1'b0; e_load = 1'b0; e_pc = 32'h0;
      e_cnt   = m_cnt; e_wdog  = m_wdog;
      if (rst) begin
         e_stall = 6'h3F; e_load = 1'b1; e_pc = word(RESET_VEC);
         e_cnt = 0; e_wdog = 1'b0;
      end else if (m_phase == 0) begin
         e_stall = 6'h3F; e_load = 1'b1; e_pc = word(RESET_VEC);
      end else if (m_phase == 2) begin
         e_flush = 1'b1;
      end else if (exc_valid) begin
         e_flush = 1'b1; e_load = 1'b1;
         e_pc = word(exc_eret ? epc : EXC_VEC);
      end else if (stallreq_ex) begin
         e_stall = 6'h0F;
      end else if (stallreq_id) begin
         e_stall = 6'h07;
      end else if (m_pend) begin
         e_load = 1'b1; e_pc = word(m_pend_tgt);
      end else if (branch_valid) begin
         e_load = 1'b1; e_pc = word(branch_target);
      end
   endfunction

   function automatic void model_tick();
      if (rst) begin
         m_phase = 0; m_pend = 1'b0; m_cnt = 0; m_wdog = 1'b0; m_flush_left = 0;
      end else begin
         if (e_stall == 6'h00) m_cnt = 0;
         else if (m_phase == 1) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (m_cnt == WDOG_LIMIT) m_wdog = 1'b1;
         end
         if (m_phase == 0) begin
            m_phase = 1;
         end else if (m_phase == 2) begin
            m_flush_left--;
            if (m_flush_left == 0) m_phase = 1;
         end else if (exc_valid) begin
            m_phase = 2; m_flush_left = FLUSH_CYCLES; m_pend = 1'b0;
         end else if (e_stall != 6'h00) begin
            if (branch_valid) begin m_pend = 1'b1; m_pend_tgt = branch_target; end
         end else if (m_pend) begin
            if (branch_valid) m_pend_tgt = branch_target;
            else m_pend = 1'b0;
         end
      end
   endfunction

   // Drive inputs just after a rising edge, then compare mid-cycle
   task automatic step(input bit r, input bit id, input bit ex, input bit exc,
                       input bit eret, input logic [31:0] ep,
                       input bit bv, input logic [31:0] tgt);
      rst = r; stallreq_id = id; stallreq_ex = ex; exc_valid = exc;
      exc_eret = eret; epc = ep; branch_valid = bv; branch_target = tgt;
      #4;
      model_eval();
      chk("stall",     32'(stall),     32'(e_stall));
      chk("flush",     32'(flush),     32'(e_flush));
      chk("pc_load",   32'(pc_load),   32'(e_load));
      chk("pc_new",    pc_new,         e_pc);
      chk("stall_cnt", 32'(stall_cnt), 32'(e_cnt));
      chk("wdog_err",  32'(wdog_err),  32'(e_wdog));
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
         tick();
      end
   endtask

   bit wdog_seen;

   initial begin
      rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; exc_valid = 0; exc_eret = 0;
      epc = '0; branch_valid = 0; branch_target = '0;
      @(posedge clk); #1;

      // Reset held two cycles, then one HOLD cycle, then RUN
      step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("rst_stall", 32'(stall), 32'h3F);
      chk("rst_cnt", 32'(stall_cnt), 32'h0);
      tick();
      step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      tick();
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("hold_load", 32'(pc_load), 32'h1);
      chk("hold_pc", pc_new, 32'h0);
      chk("hold_stall", 32'(stall), 32'h3F);
      tick();
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("run_stall", 32'(stall), 32'h0);
      tick();
      idle(2);

      // Branch arriving under a decode stall is deferred until the stall ends
      step(0, 1, 0, 0, 0, 32'h0, 1, 32'h100);
      chk("dbr_stall0", 32'(stall), 32'h07);
      chk("dbr_load0", 32'(pc_load), 32'h0);
      tick();
      for (int i = 1; i < 3; i++) begin
         step(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
         chk("dbr_stall", 32'(stall), 32'h07);
         chk("dbr_load", 32'(pc_load), 32'h0);
         tick();
      end
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("dbr_issue", 32'(pc_load), 32'h1);
      chk("dbr_pc", pc_new, 32'h100);
      tick();
      idle(1);

      // Exception beats an execute stall; branches ignored while flushing
      step(0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
      chk("exc_flush", 32'(flush), 32'h1);
      chk("exc_stall", 32'(stall), 32'h0);
      chk("exc_pc", pc_new, 32'h20);
      tick();
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0, 0, 32'h0, 1, 32'h300);
         chk("fl_flush", 32'(flush), 32'h1);
         chk("fl_load", 32'(pc_load), 32'h0);
         tick();
      end
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("fl_done", 32'(flush), 32'h0);
      chk("fl_nobr", 32'(pc_load), 32'h0);
      tick();

      // ERET returns to the aligned epc
      step(0, 0, 0, 1, 1, 32'h0000_1237, 0, 32'h0);
      chk("eret_pc", pc_new, 32'h0000_1234);
      tick();
      idle(3);

      // Long execute stall trips the watchdog at the limit
      wdog_seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         step(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
         if (wdog_err && !wdog_seen) begin
            chk("wdog_rise_cnt", 32'(stall_cnt), 32'(WDOG_LIMIT));
            wdog_seen = 1'b1;
         end
         tick();
      end
      chk("wdog_rose", 32'(wdog_seen), 32'h1);
      idle(1);
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("wdog_cnt_clr", 32'(stall_cnt), 32'h0);
      chk("wdog_sticky", 32'(wdog_err), 32'h1);
      tick();

      // Reset during the second flush cycle
      step(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
      tick();
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("rfl_flush1", 32'(flush), 32'h1);
      tick();
      step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("rfl_rst_flush", 32'(flush), 32'h0);
      chk("rfl_rst_pc", pc_new, 32'h0);
      tick();
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("rfl_hold_flush", 32'(flush), 32'h0);
      chk("rfl_hold_stall", 32'(stall), 32'h3F);
      chk("rfl_hold_pc", pc_new, 32'h0);
      chk("rfl_wdog_clr", 32'(wdog_err), 32'h0);
      tick();

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(63) == 0),
              ($urandom_range(3) == 0),
              ($urandom_range(5) == 0),
              ($urandom_range(15) == 0),
              1'($urandom_range(1)),
              $urandom(),
              ($urandom_range(2) == 0),
              $urandom());
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
